// File: rtl/mm_pkg.sv
// Shared definitions for burst_line_memory: FSM state encoding and width helpers.
package mm_pkg;

  typedef logic [2:0] mm_state_t;

  localparam mm_state_t ST_IDLE  = 3'd0;
  localparam mm_state_t ST_WAIT  = 3'd1;
  localparam mm_state_t ST_BURST = 3'd2;
  localparam mm_state_t ST_WRITE = 3'd3;
  localparam mm_state_t ST_DONE  = 3'd4;

  function automatic int line_w(input int width, input int words);
    return width * words;
  endfunction

  function automatic int offset_w(input int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  // Counter width never drops to zero so a one-word line still has a legal register.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mm_storage_array.sv
// Single-port word RAM: combinational read at addr, bit-masked synchronous write.
module mm_storage_array #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH-1:0]     wmask,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_SIZE];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
  end

endmodule

// File: rtl/burst_line_memory.sv
// burst_line_memory: word-write / full-line burst-read backing store with access latency.
// Defining MM_BYTE_STROBE_EN adds the wstrb port and byte-granular writes.
module burst_line_memory
  import mm_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_SIZE      = 10,
  parameter int WORDS_PER_LINE = 4,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        read_en,
  input  logic                                        write_en,
  input  logic [ADDR_SIZE-1:0]                        address,
  input  logic [WIDTH-1:0]                            DataIn,
`ifdef MM_BYTE_STROBE_EN
  input  logic [WIDTH/8-1:0]                          wstrb,
`endif
  output logic                                        busy,
  output logic                                        ready_signal_memory,
  output logic [line_w(WIDTH, WORDS_PER_LINE)-1:0]    DataOut
);

  localparam int                   CNT_W     = cnt_w(WORDS_PER_LINE);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK  = ADDR_SIZE'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]     LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
  localparam bit                   HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [7:0]           WAIT_LOAD = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mm_state_t            state;
  logic                 op_write;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     mask_q;
  logic [7:0]           wait_cnt;
  logic [CNT_W-1:0]     word_cnt;

  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_rdata;
  logic [WIDTH-1:0]     req_mask;

`ifdef MM_BYTE_STROBE_EN
  always_comb begin
    req_mask = '0;
    for (int b = 0; b < WIDTH / 8; b++) req_mask[b*8 +: 8] = {8{wstrb[b]}};
  end
`else
  assign req_mask = '1;
`endif

  // addr_q holds the line base for reads, so OR-ing the counter walks the line without wrap.
  assign mem_addr            = addr_q | ADDR_SIZE'(word_cnt);
  assign busy                = (state != ST_IDLE);
  assign ready_signal_memory = (state == ST_DONE);

  mm_storage_array #(
    .WIDTH     (WIDTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_storage (
    .clk   (clk),
    .we    (state == ST_WRITE),
    .addr  (mem_addr),
    .wdata (data_q),
    .wmask (mask_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      wait_cnt <= '0;
      word_cnt <= '0;
      DataOut  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (write_en) begin
            op_write <= 1'b1;
            addr_q   <= address;
            data_q   <= DataIn;
            mask_q   <= req_mask;
            wait_cnt <= WAIT_LOAD;
            state    <= HAS_WAIT ? ST_WAIT : ST_WRITE;
          end else if (read_en) begin
            op_write <= 1'b0;
            addr_q   <= address & ~OFF_MASK;
            wait_cnt <= WAIT_LOAD;
            state    <= HAS_WAIT ? ST_WAIT : ST_BURST;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 8'd0) state <= op_write ? ST_WRITE : ST_BURST;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        ST_WRITE: state <= ST_DONE;
        ST_BURST: begin
          DataOut[int'(word_cnt)*WIDTH +: WIDTH] <= mem_rdata;
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            state    <= ST_DONE;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_memory.sv
// Bench for burst_line_memory: two instances (latency 0 and 3) against a transaction-level model.
module tb_burst_line_memory;

  localparam int W   = 32;
  localparam int AW  = 10;
  localparam int WPL = 4;
  localparam int LW  = W * WPL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re   [2];
  logic          we   [2];
  logic [AW-1:0] addr [2];
  logic [W-1:0]  din  [2];
  logic [3:0]    strb [2];
  logic          busy [2];
  logic          rdy  [2];
  logic [LW-1:0] dout [2];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_line_memory #(.WIDTH(W), .ADDR_SIZE(AW), .WORDS_PER_LINE(WPL), .WAIT_CYCLES(0)) u_mem0 (
    .clk(clk), .rst(rst), .read_en(re[0]), .write_en(we[0]), .address(addr[0]), .DataIn(din[0]),
`ifdef MM_BYTE_STROBE_EN
    .wstrb(strb[0]),
`endif
    .busy(busy[0]), .ready_signal_memory(rdy[0]), .DataOut(dout[0])
  );

  burst_line_memory #(.WIDTH(W), .ADDR_SIZE(AW), .WORDS_PER_LINE(WPL), .WAIT_CYCLES(3)) u_mem3 (
    .clk(clk), .rst(rst), .read_en(re[1]), .write_en(we[1]), .address(addr[1]), .DataIn(din[1]),
`ifdef MM_BYTE_STROBE_EN
    .wstrb(strb[1]),
`endif
    .busy(busy[1]), .ready_signal_memory(rdy[1]), .DataOut(dout[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [W-1:0] strobe_mask(input logic [3:0] s);
    logic [W-1:0] m;
    m = '1;
`ifdef MM_BYTE_STROBE_EN
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: memory image plus a countdown of cycles left until the op is over.
  logic [W-1:0]   m_mem  [2][1024];
  bit             m_kn   [2][1024];
  int             m_rem  [2];
  bit             m_opw  [2];
  logic [AW-1:0]  m_wa   [2];
  logic [W-1:0]   m_wd   [2];
  logic [W-1:0]   m_wm   [2];
  logic [LW-1:0]  m_line [2];
  logic [LW-1:0]  m_pend [2];
  logic [WPL-1:0] m_lk   [2];
  logic [WPL-1:0] m_pk   [2];

  always @(posedge clk) begin
    logic [AW-1:0] base;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rem[k]  = 0;
        m_line[k] = '0;
        m_lk[k]   = '1;
      end else if (m_rem[k] > 0) begin
        if (m_rem[k] == 2) begin
          if (m_opw[k]) begin
            m_mem[k][m_wa[k]] = (m_mem[k][m_wa[k]] & ~m_wm[k]) | (m_wd[k] & m_wm[k]);
            if (m_wm[k] == '1) m_kn[k][m_wa[k]] = 1'b1;
          end else begin
            m_line[k] = m_pend[k];
            m_lk[k]   = m_pk[k];
          end
        end
        m_rem[k]--;
      end else if (we[k]) begin
        m_opw[k] = 1'b1;
        m_wa[k]  = addr[k];
        m_wd[k]  = din[k];
        m_wm[k]  = strobe_mask(strb[k]);
        m_rem[k] = wait_of(k) + 2;
      end else if (re[k]) begin
        m_opw[k] = 1'b0;
        base = addr[k] & ~AW'(WPL - 1);
        for (int s = 0; s < WPL; s++) begin
          m_pend[k][s*W +: W] = m_mem[k][base + AW'(s)];
          m_pk[k][s]          = m_kn[k][base + AW'(s)];
        end
        m_rem[k] = wait_of(k) + WPL + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), LW'(busy[k]), LW'(m_rem[k] > 0));
        chk($sformatf("ready%0d", k), LW'(rdy[k]), LW'(m_rem[k] == 1));
        if (m_rem[k] <= 1)
          for (int s = 0; s < WPL; s++)
            if (m_lk[k][s])
              chk($sformatf("dataout%0d_slot%0d", k, s), LW'(dout[k][s*W +: W]), LW'(m_line[k][s*W +: W]));
      end
    end
  end

  task automatic issue(input int k, input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [3:0] s, input int exp_lat,
                       input bit hold, output logic [LW-1:0] line);
    int t0;
    bit seen;
    line = '0;
    @(posedge clk); #1;
    we[k] = w; re[k] = r; addr[k] = a; din[k] = d; strb[k] = s;
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) begin we[k] = 1'b0; re[k] = 1'b0; end
    addr[k] = a ^ '1;
    din[k]  = ~d;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        seen  = 1'b1;
        line  = dout[k];
        we[k] = 1'b0; re[k] = 1'b0;
        chk("ready_latency", LW'(cyc + 1 - t0), LW'(exp_lat));
      end
    end
    we[k] = 1'b0; re[k] = 1'b0;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: got no ready within 300 cycles, expected latency %0d", exp_lat);
    end else begin
      @(negedge clk);
      chk("ready_one_cycle", LW'(rdy[k]), '0);
    end
  endtask

  task automatic abort_op(input int k, input bit w, input logic [AW-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    we[k] = w; re[k] = !w; addr[k] = a; din[k] = d; strb[k] = 4'hF;
    @(posedge clk); #1;
    we[k] = 1'b0; re[k] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", LW'(busy[k]), '0);
    chk("abort_ready", LW'(rdy[k]), '0);
    chk("abort_dataout", dout[k], '0);
    rst = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] line;
    for (int k = 0; k < 2; k++) begin
      re[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; din[k] = '0; strb[k] = 4'hF;
    end
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", LW'(busy[k]), '0);
      chk("reset_ready", LW'(rdy[k]), '0);
      chk("reset_dataout", dout[k], '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) issue(0, 1, 0, AW'(8 + i), 32'hA5A5_0001 + W'(i), 4'hF, 2, 0, line);
    issue(0, 0, 1, 10'd10, '0, 4'hF, 5, 0, line);
    chk("line8_read", line, 128'hA5A50004_A5A50003_A5A50002_A5A50001);

    for (int i = 0; i < 4; i++) issue(1, 1, 0, AW'(4 + i), 32'h5555_0004 + W'(i), 4'hF, 5, 0, line);
    issue(1, 0, 1, 10'd6, '0, 4'hF, 8, 0, line);
    chk("line4_wait_read", line, 128'h55550007_55550006_55550005_55550004);

    issue(0, 1, 1, 10'd12, 32'hDEAD_BEEF, 4'hF, 2, 1, line);
    repeat (4) @(negedge clk);
    chk("no_extra_ready", LW'(rdy[0]), '0);
    issue(0, 0, 1, 10'd13, '0, 4'hF, 5, 0, line);
    chk("line12_slot0", LW'(line[31:0]), LW'(32'hDEAD_BEEF));

    abort_op(0, 0, 10'd9, '0);
    abort_op(1, 1, 10'd5, 32'h0BAD_0BAD);
    issue(1, 0, 1, 10'd4, '0, 4'hF, 8, 0, line);
    chk("abort_kept_word", LW'(line[63:32]), LW'(32'h5555_0005));
    issue(0, 0, 1, 10'd8, '0, 4'hF, 5, 0, line);
    chk("line8_after_abort", line, 128'hA5A50004_A5A50003_A5A50002_A5A50001);

    for (int i = 0; i < 4; i++) issue(0, 1, 0, AW'(1020 + i), 32'hEE00_0000 + W'(1020 + i), 4'hF, 2, 0, line);
    for (int i = 0; i < 4; i++) issue(0, 1, 0, AW'(i), 32'h1100_0000 + W'(i), 4'hF, 2, 0, line);
    issue(0, 0, 1, 10'd1021, '0, 4'hF, 5, 0, line);
    chk("last_line", line, 128'hEE0003FF_EE0003FE_EE0003FD_EE0003FC);
    issue(0, 0, 1, 10'd2, '0, 4'hF, 5, 0, line);
    chk("line0", line, 128'h11000003_11000002_11000001_11000000);

`ifdef MM_BYTE_STROBE_EN
    issue(0, 1, 0, 10'd3, 32'h1122_3344, 4'hF, 2, 0, line);
    issue(0, 1, 0, 10'd3, 32'hAABB_CCDD, 4'b0101, 2, 0, line);
    issue(0, 1, 0, 10'd3, 32'hFFFF_FFFF, 4'b0000, 2, 0, line);
    issue(0, 0, 1, 10'd0, '0, 4'hF, 5, 0, line);
    chk("strobe_word", LW'(line[127:96]), LW'(32'h11BB_33DD));
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
